// File: rtl/mem_responder_pkg.sv
// Shared definitions for the mem_responder block: default geometry and FSM states.
package mem_responder_pkg;

    localparam int unsigned MR_DEPTH = 8;
    localparam int unsigned MR_WIDTH = 24;
    localparam int unsigned MR_AW    = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } mr_state_e;

endpackage

// File: rtl/mem_responder_decode.sv
// Binary address to one-hot word select; all zeros when disabled.
module mem_responder_decode
    import mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH = MR_DEPTH,
    parameter int unsigned AW    = MR_AW
) (
    input  logic [AW-1:0]    addr_i,
    input  logic             en_i,
    output logic [DEPTH-1:0] onehot_o
);

    // Drive exactly one select line for the given address when enabled.
    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            onehot_o[addr_i] = 1'b1;
        end else begin
            onehot_o = '0;
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding request/response memory responder with an auto-increment
// pointer. Each transaction walks IDLE -> ACCESS -> RESP; per-word valid bits
// flag reads of words that were never written since reset.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH = MR_DEPTH,
    parameter int unsigned WIDTH = MR_WIDTH,
    parameter int unsigned AW    = MR_AW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic             req_incr,
    input  logic [AW-1:0]    req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             rsp_err,
    output logic [DEPTH-1:0] word_line,
    output logic [AW-1:0]    mem_pointer
);

    mr_state_e        state_q,     state_d;
    logic [AW-1:0]    addr_q,      addr_d;
    logic             write_q,     write_d;
    logic [WIDTH-1:0] wdata_q,     wdata_d;
    logic [AW-1:0]    ptr_q,       ptr_d;
    logic [DEPTH-1:0] valid_q,     valid_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic             rsp_err_q,   rsp_err_d;
    logic [DEPTH-1:0] word_line_q, word_line_d;
    logic             req_ready_q, req_ready_d;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             mem_we_s;
    logic             accept_s;
    logic [AW-1:0]    res_addr_s;
    logic [DEPTH-1:0] dec_s;

    // An incrementing request targets the pointer, otherwise the explicit address.
    assign res_addr_s = req_incr ? ptr_q : req_addr;
    assign accept_s   = (state_q == ST_IDLE) && req_valid;

    // The select is computed at accept time and registered, so it is high
    // exactly during the ACCESS cycle.
    mem_responder_decode #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_decode (
        .addr_i   (res_addr_s),
        .en_i     (accept_s),
        .onehot_o (dec_s)
    );

    // Next-state and next-output logic for the transaction FSM.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        write_d     = write_q;
        wdata_d     = wdata_q;
        ptr_d       = ptr_q;
        valid_d     = valid_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        word_line_d = '0;
        req_ready_d = req_ready_q;
        mem_we_s    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d     = ST_ACCESS;
                    addr_d      = res_addr_s;
                    write_d     = req_write;
                    wdata_d     = req_wdata;
                    word_line_d = dec_s;
                    req_ready_d = 1'b0;
                    if (req_incr) begin
                        ptr_d = ptr_q + AW'(1);
                    end else begin
                        ptr_d = ptr_q;
                    end
                end else begin
                    req_ready_d = 1'b1;
                end
            end

            ST_ACCESS: begin
                state_d     = ST_RESP;
                rsp_valid_d = 1'b1;
                req_ready_d = 1'b0;
                if (write_q) begin
                    mem_we_s         = 1'b1;
                    valid_d[addr_q]  = 1'b1;
                    rsp_rdata_d      = '0;
                    rsp_err_d        = 1'b0;
                end else if (valid_q[addr_q]) begin
                    rsp_rdata_d = mem_q[addr_q];
                    rsp_err_d   = 1'b0;
                end else begin
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                end
            end

            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                    req_ready_d = 1'b1;
                end else begin
                    state_d     = ST_RESP;
                    req_ready_d = 1'b0;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                rsp_valid_d = 1'b0;
                rsp_rdata_d = '0;
                rsp_err_d   = 1'b0;
                req_ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            write_q     <= 1'b0;
            wdata_q     <= '0;
            ptr_q       <= '0;
            valid_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            word_line_q <= '0;
            req_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            write_q     <= write_d;
            wdata_q     <= wdata_d;
            ptr_q       <= ptr_d;
            valid_q     <= valid_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            word_line_q <= word_line_d;
            req_ready_q <= req_ready_d;
        end
    end

    // Data array is not cleared by reset; the valid bits decide what is readable.
    always_ff @(posedge clk) begin
        if (!rst && mem_we_s) begin
            mem_q[addr_q] <= wdata_q;
        end
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign word_line   = word_line_q;
    assign mem_pointer = ptr_q;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench for mem_responder against an array-based model.
module tb_mem_responder;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_incr;
    logic [2:0]  req_addr;
    logic [23:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [23:0] rsp_rdata;
    logic        rsp_err;
    logic [7:0]  word_line;
    logic [2:0]  mem_pointer;

    mem_responder dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_incr    (req_incr),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .word_line   (word_line),
        .mem_pointer (mem_pointer)
    );

    // Reference model: plain arrays for data and written-flags, plus the pointer.
    logic [23:0] mem_m   [8];
    logic        valid_m [8];
    logic [2:0]  ptr_m;

    int n_chk;
    int n_pass;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (obs === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) valid_m[i] = 1'b0;
        ptr_m = 3'd0;
    endtask

    // One full transaction. Starts and ends 1 time unit after a rising edge with
    // the DUT in IDLE. hold = cycles rsp_ready is kept low in RESP; poke drives a
    // competing request during that hold, which must be ignored.
    task automatic do_txn(input logic wr, input logic inc, input logic [2:0] a,
                          input logic [23:0] d, input int hold, input logic poke);
        logic [2:0]  ea;
        logic [7:0]  wl_e;
        logic [23:0] exp_d;
        logic        exp_e;
        chk("idle_req_ready", 32'(req_ready), 32'd1);
        chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
        ea        = inc ? ptr_m : a;
        wl_e      = 8'd1 << ea;
        req_valid = 1'b1;
        req_write = wr;
        req_incr  = inc;
        req_addr  = a;
        req_wdata = d;
        rsp_ready = 1'b1;
        tick();
        // ACCESS cycle
        if (inc) ptr_m = ptr_m + 3'd1;
        req_valid = 1'b0;
        chk("acc_word_line", 32'(word_line), 32'(wl_e));
        chk("acc_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("acc_req_ready", 32'(req_ready), 32'd0);
        chk("acc_pointer", 32'(mem_pointer), 32'(ptr_m));
        if (wr) begin
            mem_m[ea]   = d;
            valid_m[ea] = 1'b1;
            exp_d       = 24'd0;
            exp_e       = 1'b0;
        end else if (valid_m[ea]) begin
            exp_d = mem_m[ea];
            exp_e = 1'b0;
        end else begin
            exp_d = 24'd0;
            exp_e = 1'b1;
        end
        if (hold > 0) rsp_ready = 1'b0;
        tick();
        // RESP cycle: two cycles after the request was presented
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_d));
        chk("rsp_err", 32'(rsp_err), 32'(exp_e));
        chk("rsp_word_line", 32'(word_line), 32'd0);
        chk("rsp_req_ready", 32'(req_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            if (poke) begin
                req_valid = 1'b1;
                req_write = 1'b1;
                req_incr  = 1'b1;
                req_wdata = 24'hDEAD00;
            end
            tick();
            chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("hold_rsp_rdata", 32'(rsp_rdata), 32'(exp_d));
            chk("hold_rsp_err", 32'(rsp_err), 32'(exp_e));
            chk("hold_req_ready", 32'(req_ready), 32'd0);
            chk("hold_pointer", 32'(mem_pointer), 32'(ptr_m));
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        chk("done_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("done_req_ready", 32'(req_ready), 32'd1);
        chk("done_pointer", 32'(mem_pointer), 32'(ptr_m));
        rsp_ready = 1'b0;
    endtask

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Main stimulus sequence.
    initial begin
        int accepts;
        int first_acc;
        int last_acc;
        n_chk     = 0;
        n_pass    = 0;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_incr  = 1'b0;
        req_addr  = 3'd0;
        req_wdata = 24'd0;
        rsp_ready = 1'b0;
        model_reset();
        tick();
        tick();
        rst = 1'b0;

        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_word_line", 32'(word_line), 32'd0);
        chk("rst_pointer", 32'(mem_pointer), 32'd0);

        // Read of a never-written word errors.
        do_txn(1'b0, 1'b0, 3'd3, 24'd0, 0, 1'b0);

        // Write then read back the same word.
        do_txn(1'b1, 1'b0, 3'd5, 24'h00A5A5, 0, 1'b0);
        do_txn(1'b0, 1'b0, 3'd5, 24'd0, 0, 1'b0);
        chk("wr_rd_a5a5", 32'(rsp_rdata_last(5)), 32'h00A5A5);

        // Nine incrementing writes wrap the pointer.
        for (int k = 1; k <= 9; k++) do_txn(1'b1, 1'b1, 3'd0, 24'(k), 0, 1'b0);
        chk("incr_final_ptr", 32'(mem_pointer), 32'd1);
        for (int k = 0; k < 8; k++) do_txn(1'b0, 1'b0, 3'(k), 24'd0, 0, 1'b0);

        // Stalled response with a competing request.
        do_txn(1'b0, 1'b0, 3'd0, 24'd0, 5, 1'b1);
        do_txn(1'b0, 1'b0, 3'd1, 24'd0, 0, 1'b0);

        // Reset during the ACCESS cycle of a write to word 2.
        req_valid = 1'b1;
        req_write = 1'b1;
        req_incr  = 1'b0;
        req_addr  = 3'd2;
        req_wdata = 24'h123456;
        tick();
        req_valid = 1'b0;
        rst       = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort_req_ready", 32'(req_ready), 32'd1);
        chk("abort_word_line", 32'(word_line), 32'd0);
        chk("abort_pointer", 32'(mem_pointer), 32'd0);
        tick();
        chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
        do_txn(1'b0, 1'b0, 3'd2, 24'd0, 0, 1'b0);

        // Randomized traffic.
        for (int k = 0; k < 40; k++) begin
            do_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   3'($urandom_range(0, 7)), 24'($urandom),
                   int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        // Back-to-back requests with rsp_ready held high.
        do_txn(1'b1, 1'b0, 3'd6, 24'h0BEEF0, 0, 1'b0);
        accepts   = 0;
        first_acc = -1;
        last_acc  = -1;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_incr  = 1'b0;
        req_addr  = 3'd6;
        rsp_ready = 1'b1;
        for (int c = 0; c < 9; c++) begin
            if (req_ready) begin
                accepts = accepts + 1;
                if (first_acc < 0) first_acc = c;
                last_acc = c;
            end
            if (rsp_valid) chk("b2b_rdata", 32'(rsp_rdata), 32'(mem_m[6]));
            tick();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        chk("b2b_accepts", 32'(accepts), 32'd3);
        chk("b2b_spacing", 32'(last_acc - first_acc), 32'd6);
        tick();
        chk("b2b_idle", 32'(req_ready), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    function automatic logic [23:0] rsp_rdata_last(input int unused);
        return (unused >= 0) ? mem_m[5] : 24'd0;
    endfunction

endmodule
